box_cmd_rx: RTL



---
 rtl/box_cmd_rx.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/box_cmd_rx.sv
// box_cmd_rx: parses framed box-command packets from the UDP RX byte stream,
// validates framing/count/length/coordinates/checksum and atomically commits
// accepted boxes to flattened draw-box output buses.
// Optional feature macro: BOX_CMD_TIMEOUT_EN (idle timeout clears the boxes).
module box_cmd_rx #(
    parameter int unsigned N_BOX = 1,
    parameter int unsigned H_ACT = 1280,
    parameter int unsigned V_ACT = 720,
    parameter logic [7:0]  MAGIC = 8'hA5
`ifdef BOX_CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 125_000_000
`endif
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic [N_BOX*$clog2(H_ACT)-1:0] start_xs,
    output logic [N_BOX*$clog2(V_ACT)-1:0] start_ys,
    output logic [N_BOX*$clog2(H_ACT)-1:0] end_xs,
    output logic [N_BOX*$clog2(V_ACT)-1:0] end_ys,
    output logic [N_BOX*24-1:0]            colors,
    output logic [N_BOX-1:0]               box_valid,
    output logic                          commit,
    output logic [7:0]                    err_cnt,
    output logic                          error
);
    localparam int unsigned XW = $clog2(H_ACT);
    localparam int unsigned YW = $clog2(V_ACT);

    typedef enum logic [2:0] {StIdle, StCnt, StBody, StCsum, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              n_q, n_d;
    logic [7:0]              box_q, box_d;
    logic [2:0]              byte_q, byte_d;
    logic [39:0]             rec_q, rec_d;     // first five bytes of the current record
    logic [7:0]              csum_q, csum_d;
    logic                    bad_q, bad_d;     // reject pending until end of packet
    logic [N_BOX-1:0][47:0]  shadow_q, shadow_d;
    logic                    accept, reject, tmo_clear;

    logic [N_BOX*XW-1:0]     sx_q, sx_d, ex_q, ex_d;
    logic [N_BOX*YW-1:0]     sy_q, sy_d, ey_q, ey_d;
    logic [N_BOX*24-1:0]     col_q, col_d;
    logic [N_BOX-1:0]        bv_q, bv_d;
    logic [7:0]              err_q, err_d;
    logic                    commit_q, error_q;

    // Complete record as it stands when its sixth byte arrives.
    logic [47:0] full;
    logic        coord_ok;
    assign full     = {rec_q, rx_data};
    assign coord_ok = (full[47:37] <= full[26:16]) && (full[36:27] <= full[15:6]) &&
                      (32'(full[26:16]) < H_ACT) && (32'(full[15:6]) < V_ACT);

    // Parser next-state: framing, count, record capture, checksum and drain.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        box_d    = box_q;
        byte_d   = byte_q;
        rec_d    = rec_q;
        csum_d   = csum_q;
        bad_d    = bad_q;
        shadow_d = shadow_q;
        accept   = 1'b0;
        reject   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    csum_d  = rx_data;
                    box_d   = 8'd0;
                    byte_d  = 3'd0;
                    bad_d   = (rx_data != MAGIC);
                    state_d = (rx_data == MAGIC) ? StCnt : StDrain;
                end
            end
            StCnt: begin
                if (!rx_valid) begin
                    reject  = 1'b1;
                    state_d = StIdle;
                end else begin
                    csum_d = csum_q ^ rx_data;
                    n_d    = rx_data;
                    if (rx_data != 8'd0 && 32'(rx_data) <= N_BOX) begin
                        state_d = StBody;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StBody: begin
                if (!rx_valid) begin
                    reject  = 1'b1;
                    state_d = StIdle;
                end else begin
                    csum_d = csum_q ^ rx_data;
                    rec_d  = {rec_q[31:0], rx_data};
                    if (byte_q == 3'd5) begin
                        byte_d = 3'd0;
                        box_d  = box_q + 8'd1;
                        if (!coord_ok) bad_d = 1'b1;
                        for (int unsigned i = 0; i < N_BOX; i++) begin
                            if (32'(box_q) == i) shadow_d[i] = full;
                        end
                        if (box_q + 8'd1 == n_q) state_d = StCsum;
                    end else begin
                        byte_d = byte_q + 3'd1;
                    end
                end
            end
            StCsum: begin
                if (!rx_valid) begin
                    reject  = 1'b1;
                    state_d = StIdle;
                end else begin
                    if (rx_data != csum_q) bad_d = 1'b1;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (rx_valid) begin
                    bad_d = 1'b1;   // any byte past the checksum makes the packet too long
                end else begin
                    accept  = !bad_q;
                    reject  = bad_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef BOX_CMD_TIMEOUT_EN
    logic [26:0] idle_q, idle_d;
    // Idle counter restarts on commit and parks at TIMEOUT-1 to keep outputs cleared.
    always_comb begin
        idle_d = idle_q;
        if (accept) idle_d = 27'd0;
        else if (idle_q != 27'(TIMEOUT - 1)) idle_d = idle_q + 27'd1;
    end
    assign tmo_clear = (idle_q == 27'(TIMEOUT - 1));

    // Idle counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) idle_q <= 27'd0;
        else       idle_q <= idle_d;
    end
`else
    assign tmo_clear = 1'b0;
`endif

    // Output next-state: atomic commit of shadow boxes, timeout clear, error count.
    always_comb begin
        sx_d  = sx_q;
        sy_d  = sy_q;
        ex_d  = ex_q;
        ey_d  = ey_q;
        col_d = col_q;
        bv_d  = bv_q;
        err_d = err_q;
        if (accept) begin
            for (int unsigned i = 0; i < N_BOX; i++) begin
                if (i < 32'(n_q)) begin
                    sx_d[i*XW +: XW]  = XW'(shadow_q[i][47:37]);
                    sy_d[i*YW +: YW]  = YW'(shadow_q[i][36:27]);
                    ex_d[i*XW +: XW]  = XW'(shadow_q[i][26:16]);
                    ey_d[i*YW +: YW]  = YW'(shadow_q[i][15:6]);
                    col_d[i*24 +: 24] = {{4{shadow_q[i][5:4]}}, {4{shadow_q[i][3:2]}},
                                         {4{shadow_q[i][1:0]}}};
                    bv_d[i]           = 1'b1;
                end else begin
                    sx_d[i*XW +: XW]  = '0;
                    sy_d[i*YW +: YW]  = '0;
                    ex_d[i*XW +: XW]  = '0;
                    ey_d[i*YW +: YW]  = '0;
                    col_d[i*24 +: 24] = '0;
                    bv_d[i]           = 1'b0;
                end
            end
        end else if (tmo_clear) begin
            sx_d  = '0;
            sy_d  = '0;
            ex_d  = '0;
            ey_d  = '0;
            col_d = '0;
            bv_d  = '0;
        end
        if (reject && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    // State and output registers; reset discards any partial packet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            n_q      <= 8'd0;
            box_q    <= 8'd0;
            byte_q   <= 3'd0;
            rec_q    <= 40'd0;
            csum_q   <= 8'd0;
            bad_q    <= 1'b0;
            shadow_q <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            ex_q     <= '0;
            ey_q     <= '0;
            col_q    <= '0;
            bv_q     <= '0;
            err_q    <= 8'd0;
            commit_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            box_q    <= box_d;
            byte_q   <= byte_d;
            rec_q    <= rec_d;
            csum_q   <= csum_d;
            bad_q    <= bad_d;
            shadow_q <= shadow_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            ex_q     <= ex_d;
            ey_q     <= ey_d;
            col_q    <= col_d;
            bv_q     <= bv_d;
            err_q    <= err_d;
            commit_q <= accept;
            error_q  <= reject;
        end
    end

    assign start_xs  = sx_q;
    assign start_ys  = sy_q;
    assign end_xs    = ex_q;
    assign end_ys    = ey_q;
    assign colors    = col_q;
    assign box_valid = bv_q;
    assign err_cnt   = err_q;
    assign commit    = commit_q;
    assign error     = error_q;
endmodule
